host_xact_ctrl: RTL

Host-side USB 2.0 link transaction controller, the initiator counterpart of the device-side link controller. On request it issues a token (OUT/IN/SETUP), sends or receives the data stage, and handles the handshake stage. It drives the TX group (token/data/handshake) and consumes RX group results. It owns bus-direction control (d_oe), response timeout and bounded retry, and reports one result per transaction.

---
 rtl/host_xact_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/host_xact_ctrl.sv
// Host-side USB 2.0 transaction initiator: token, data stage and handshake,
// with a response timeout and bounded reissue of the whole transaction.
module host_xact_ctrl #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd816,
    parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       xact_start,
    input  logic [1:0] xact_dir,
    input  logic [6:0] dev_addr,
    input  logic [3:0] dev_ep,
    input  logic       data_tgl,
    output logic       busy,
    output logic       d_oe,
    output logic       tx_start,
    output logic [1:0] tx_type,
    output logic [3:0] tx_pid,
    output logic [6:0] tok_addr,
    output logic [3:0] tok_ep,
    input  logic       tx_done,
    input  logic       rx_pkt_valid,
    input  logic [3:0] rx_pid_val,
    input  logic       crc5_err,
    input  logic       crc16_err,
    output logic       xact_done,
    output logic [2:0] xact_result,
    output logic       data_accept,
    output logic       time_out
);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [2:0] RES_ACK     = 3'b000;
    localparam logic [2:0] RES_NAK     = 3'b001;
    localparam logic [2:0] RES_STALL   = 3'b010;
    localparam logic [2:0] RES_TIMEOUT = 3'b011;
    localparam logic [2:0] RES_CRC     = 3'b100;
    localparam logic [2:0] RES_PID     = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE, S_TOK_TX, S_DATA_TX, S_HS_WAIT, S_DATA_WAIT, S_ACK_TX, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        entry_q, entry_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  retry_q, retry_d;
    logic [1:0]  dir_q, dir_d;
    logic        tgl_q, tgl_d;
    logic [6:0]  addr_q, addr_d;
    logic [3:0]  ep_q, ep_d;
    logic [2:0]  result_q, result_d;

    logic        retry_req;
    logic        retry_crc;
    logic        expired;
    logic        is_in;
    logic [3:0]  tok_pid;
    logic [3:0]  data_pid;
    logic        unused_crc5;

    // Tokens are never received by a host, so the CRC5 flag carries no information here.
    assign unused_crc5 = crc5_err;

    assign is_in       = (dir_q == 2'b01);
    assign tok_pid     = (dir_q == 2'b01) ? PID_IN : ((dir_q == 2'b10) ? PID_SETUP : PID_OUT);
    assign data_pid    = (tgl_q && dir_q != 2'b10) ? PID_DATA1 : PID_DATA0;
    assign expired     = (timer_q == TIMEOUT_CYC - 16'd1);
    assign busy        = (state_q != S_IDLE);
    assign tok_addr    = addr_q;
    assign tok_ep      = ep_q;
    assign xact_result = result_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        retry_d     = retry_q;
        dir_d       = dir_q;
        tgl_d       = tgl_q;
        addr_d      = addr_q;
        ep_d        = ep_q;
        result_d    = result_q;
        retry_req   = 1'b0;
        retry_crc   = 1'b0;
        d_oe        = 1'b0;
        tx_start    = 1'b0;
        tx_type     = 2'b00;
        tx_pid      = 4'b0000;
        xact_done   = 1'b0;
        data_accept = 1'b0;
        time_out    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (xact_start) begin
                    dir_d   = (xact_dir == 2'b11) ? 2'b00 : xact_dir;
                    tgl_d   = data_tgl;
                    addr_d  = dev_addr;
                    ep_d    = dev_ep;
                    retry_d = 2'd0;
                    state_d = S_TOK_TX;
                end
            end
            S_TOK_TX: begin
                d_oe     = 1'b1;
                tx_start = entry_q;
                tx_type  = 2'b01;
                tx_pid   = tok_pid;
                if (!entry_q && tx_done) begin
                    state_d = is_in ? S_DATA_WAIT : S_DATA_TX;
                end
            end
            S_DATA_TX: begin
                d_oe     = 1'b1;
                tx_start = entry_q;
                tx_type  = 2'b10;
                tx_pid   = data_pid;
                if (!entry_q && tx_done) begin
                    state_d = S_HS_WAIT;
                end
            end
            S_HS_WAIT: begin
                timer_d = timer_q + 16'd1;
                if (rx_pkt_valid) begin
                    state_d = S_DONE;
                    case (rx_pid_val)
                        PID_ACK:   result_d = RES_ACK;
                        PID_NAK:   result_d = RES_NAK;
                        PID_STALL: result_d = RES_STALL;
                        default:   result_d = RES_PID;
                    endcase
                end else if (expired) begin
                    time_out  = 1'b1;
                    retry_req = 1'b1;
                end
            end
            S_DATA_WAIT: begin
                timer_d = timer_q + 16'd1;
                if (rx_pkt_valid) begin
                    if (crc16_err) begin
                        retry_req = 1'b1;
                        retry_crc = 1'b1;
                    end else begin
                        case (rx_pid_val)
                            PID_DATA0, PID_DATA1: begin
                                // Wrong-toggle data is a resend of data we already have: ACK it, drop it.
                                state_d     = S_ACK_TX;
                                data_accept = ((rx_pid_val == PID_DATA1) == tgl_q);
                            end
                            PID_NAK: begin
                                state_d  = S_DONE;
                                result_d = RES_NAK;
                            end
                            PID_STALL: begin
                                state_d  = S_DONE;
                                result_d = RES_STALL;
                            end
                            default: begin
                                state_d  = S_DONE;
                                result_d = RES_PID;
                            end
                        endcase
                    end
                end else if (expired) begin
                    time_out  = 1'b1;
                    retry_req = 1'b1;
                end
            end
            S_ACK_TX: begin
                d_oe     = 1'b1;
                tx_start = entry_q;
                tx_type  = 2'b00;
                tx_pid   = PID_ACK;
                if (!entry_q && tx_done) begin
                    state_d  = S_DONE;
                    result_d = RES_ACK;
                end
            end
            S_DONE: begin
                xact_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (retry_req) begin
            if (retry_q < MAX_RETRY) begin
                retry_d = retry_q + 2'd1;
                state_d = S_TOK_TX;
            end else begin
                state_d  = S_DONE;
                result_d = retry_crc ? RES_CRC : RES_TIMEOUT;
            end
        end

        entry_d = (state_d != state_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            entry_q  <= 1'b0;
            timer_q  <= '0;
            retry_q  <= '0;
            dir_q    <= '0;
            tgl_q    <= 1'b0;
            addr_q   <= '0;
            ep_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            dir_q    <= dir_d;
            tgl_q    <= tgl_d;
            addr_q   <= addr_d;
            ep_q     <= ep_d;
            result_q <= result_d;
        end
    end

endmodule
